// File: rtl/xi_ingress_arb_if.sv
// Handshake bundle between the torus IRS_N ingress channels, the merger and the node crossbar.
// The master side drives the ingress packets and the downstream ready; the slave side is the merger.
interface xi_ingress_arb_if #(
    parameter int NUM_IN = 7,
    parameter int PKT_W  = 23
);
    logic [NUM_IN-1:0]       in_vld;
    logic [NUM_IN-1:0]       in_rdy;
    logic [NUM_IN*PKT_W-1:0] in_pkt;
    logic                    out_vld;
    logic                    out_rdy;
    logic [PKT_W-1:0]        out_pkt;
    logic [2:0]              out_port;
    logic                    starve_ev;

    modport master (
        output in_vld, in_pkt, out_rdy,
        input  in_rdy, out_vld, out_pkt, out_port, starve_ev
    );

    modport slave (
        input  in_vld, in_pkt, out_rdy,
        output in_rdy, out_vld, out_pkt, out_port, starve_ev
    );
endinterface

// File: rtl/xi_ingress_arb.sv
// Per-direction torus ingress merger: 2-deep FIFO per channel, QoS strict-priority round-robin
// arbitration into one registered output stream, with a starvation guard for the low class.
module xi_ingress_arb #(
    parameter int NUM_IN     = 7,
    parameter int PKT_W      = 23,
    parameter int QOS_BIT    = 20,
    parameter int STARVE_LIM = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    xi_ingress_arb_if.slave bus
);
    localparam int PORT_W = 3;
    localparam int CNT_W  = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [NUM_IN-1:0]            full;
    logic [NUM_IN-1:0]            head_vld;
    logic [NUM_IN-1:0]            push;
    logic [NUM_IN-1:0]            pop;
    logic [NUM_IN-1:0]            hi_req;
    logic [NUM_IN-1:0]            lo_req;
    logic [NUM_IN-1:0][PKT_W-1:0] head;

    logic                         out_vld_reg;
    logic [PKT_W-1:0]             out_pkt_reg;
    logic [PORT_W-1:0]            out_port_reg;
    logic                         starve_ev_reg;
    logic [PORT_W-1:0]            hi_ptr_reg;
    logic [PORT_W-1:0]            lo_ptr_reg;
    logic [CNT_W-1:0]             starve_cnt_reg;

    logic                         load;
    logic                         force_lo;
    logic                         use_lo;
    logic                         grant_en;
    logic [PORT_W:0]              hi_pick;
    logic [PORT_W:0]              lo_pick;
    logic [PORT_W-1:0]            gnt_idx;
    logic [PORT_W-1:0]            gnt_next;

    // Returns {found, index} of the first requester at or after ptr, wrapping mod NUM_IN.
    function automatic logic [PORT_W:0] rr_pick(input logic [NUM_IN-1:0] req,
                                                input logic [PORT_W-1:0] ptr);
        logic [PORT_W:0] res;
        int              idx;
        res = '0;
        // Walk from farthest to nearest so the nearest requester is the last one written.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (req[idx]) res = {1'b1, PORT_W'(idx)};
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_fifo
            logic [PKT_W-1:0] mem_reg [2];
            logic             wr_ptr_reg;
            logic             rd_ptr_reg;
            logic [1:0]       cnt_reg;

            assign full[gi]     = (cnt_reg == 2'd2);
            assign head_vld[gi] = (cnt_reg != 2'd0);
            assign head[gi]     = mem_reg[rd_ptr_reg];
            assign push[gi]     = bus.in_vld[gi] & ~full[gi];
            assign pop[gi]      = grant_en & (gnt_idx == PORT_W'(gi));
            assign hi_req[gi]   = head_vld[gi] & head[gi][QOS_BIT];
            assign lo_req[gi]   = head_vld[gi] & ~head[gi][QOS_BIT];

            always_ff @(posedge clk) begin
                if (push[gi]) mem_reg[wr_ptr_reg] <= bus.in_pkt[gi*PKT_W +: PKT_W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= 1'b0;
                    rd_ptr_reg <= 1'b0;
                    cnt_reg    <= 2'd0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= ~wr_ptr_reg;
                    if (pop[gi])  rd_ptr_reg <= ~rd_ptr_reg;
                    case ({push[gi], pop[gi]})
                        2'b10:   cnt_reg <= cnt_reg + 2'd1;
                        2'b01:   cnt_reg <= cnt_reg - 2'd1;
                        default: cnt_reg <= cnt_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Ready comes only from registered occupancy, never from in_vld or out_rdy.
    assign bus.in_rdy = ~full;

    assign load     = ~out_vld_reg | bus.out_rdy;
    assign hi_pick  = rr_pick(hi_req, hi_ptr_reg);
    assign lo_pick  = rr_pick(lo_req, lo_ptr_reg);
    assign force_lo = (starve_cnt_reg == LIM) & (|lo_req);
    assign use_lo   = force_lo | ~(|hi_req);
    assign gnt_idx  = use_lo ? lo_pick[PORT_W-1:0] : hi_pick[PORT_W-1:0];
    assign grant_en = load & (use_lo ? lo_pick[PORT_W] : hi_pick[PORT_W]);
    assign gnt_next = (gnt_idx == PORT_W'(NUM_IN - 1)) ? '0 : gnt_idx + PORT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_reg    <= 1'b0;
            out_pkt_reg    <= '0;
            out_port_reg   <= '0;
            starve_ev_reg  <= 1'b0;
            hi_ptr_reg     <= '0;
            lo_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
        end else begin
            starve_ev_reg <= 1'b0;
            if (load) begin
                out_vld_reg <= grant_en;
                if (grant_en) begin
                    out_pkt_reg   <= head[gnt_idx];
                    out_port_reg  <= gnt_idx;
                    starve_ev_reg <= force_lo;
                    if (use_lo) lo_ptr_reg <= gnt_next;
                    else        hi_ptr_reg <= gnt_next;
                end
            end
            // Counts high-class wins taken while a low-class head was waiting.
            if (!(|lo_req)) begin
                starve_cnt_reg <= '0;
            end else if (grant_en) begin
                if (use_lo)                     starve_cnt_reg <= '0;
                else if (starve_cnt_reg != LIM) starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.out_vld   = out_vld_reg;
    assign bus.out_pkt   = out_pkt_reg;
    assign bus.out_port  = out_port_reg;
    assign bus.starve_ev = starve_ev_reg;
endmodule

// File: tb/tb_xi_ingress_arb.sv
// Directed and randomized bench for xi_ingress_arb: latency, round-robin, QoS starvation guard,
// backpressure, asynchronous reset, plus a scoreboard for ordering, loss and low-class wait.
module tb_xi_ingress_arb;
    localparam int N   = 7;
    localparam int W   = 23;
    localparam int LIM = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   streak = 0;

    typedef logic [W-1:0] pkt_q_t [$];
    pkt_q_t q [N];

    xi_ingress_arb_if #(.NUM_IN(N), .PKT_W(W)) bus ();

    xi_ingress_arb #(.NUM_IN(N), .PKT_W(W), .QOS_BIT(20), .STARVE_LIM(LIM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] mk(input logic qos, input logic [5:0] src,
                                        input logic [5:0] tgt, input logic [7:0] data);
        return {2'b01, qos, src, tgt, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ch, input logic [W-1:0] p);
        bus.in_vld[ch]         = 1'b1;
        bus.in_pkt[ch*W +: W]  = p;
    endtask

    task automatic do_reset();
        bus.in_vld  = '0;
        bus.out_rdy = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < N; c++) q[c].delete();
        streak = 0;
    endtask

    // Scoreboard step for the current cycle, using values stable since the last edge.
    task automatic consume();
        int  p;
        bit  lo_seen;
        if (bus.out_vld && bus.out_rdy) begin
            p = int'(bus.out_port);
            chk("sb_port_range", 32'(p < N), 32'd1);
            if (p < N) begin
                chk("sb_nonempty", 32'(q[p].size() != 0), 32'd1);
                if (q[p].size() != 0) begin
                    chk("sb_order", 32'(bus.out_pkt), 32'(q[p][0]));
                    lo_seen = 1'b0;
                    for (int c = 0; c < N; c++) begin
                        if (c != p && q[c].size() > 0 && !q[c][0][20]) lo_seen = 1'b1;
                        if (c == p && q[c].size() > 1 && !q[c][1][20]) lo_seen = 1'b1;
                    end
                    if (bus.out_pkt[20]) begin
                        streak = lo_seen ? streak + 1 : 0;
                        chk("starve_wait", 32'(streak <= LIM + 1), 32'd1);
                    end else begin
                        streak = 0;
                    end
                    void'(q[p].pop_front());
                end
            end
        end
    endtask

    initial begin
        logic [W-1:0] p0, p1, p2, lp;
        int sq;

        bus.in_vld  = '0;
        bus.in_pkt  = '0;
        bus.out_rdy = 1'b0;
        rst_n       = 1'b0;
        tick();
        tick();
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_out_pkt", 32'(bus.out_pkt), 32'd0);
        chk("rst_out_port", 32'(bus.out_port), 32'd0);
        chk("rst_starve_ev", 32'(bus.starve_ev), 32'd0);
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'h7F);
        rst_n = 1'b1;

        // T1: single packet, two-edge latency
        do_reset();
        drive(3, 23'h01234A);
        tick();
        bus.in_vld = '0;
        chk("t1_vld_e0", 32'(bus.out_vld), 32'd0);
        tick();
        chk("t1_vld_e1", 32'(bus.out_vld), 32'd1);
        chk("t1_pkt", 32'(bus.out_pkt), 32'h01234A);
        chk("t1_port", 32'(bus.out_port), 32'd3);
        tick();
        chk("t1_vld_e2", 32'(bus.out_vld), 32'd0);

        // T2: round-robin across all seven low-class heads, then wrap
        do_reset();
        for (int c = 0; c < N; c++) drive(c, mk(1'b0, 6'(c), 6'd0, 8'(8'h10 + c)));
        tick();
        bus.in_vld = '0;
        for (int k = 0; k < N; k++) begin
            tick();
            chk("t2_port", 32'(bus.out_port), 32'(k));
            chk("t2_pkt", 32'(bus.out_pkt), 32'(mk(1'b0, 6'(k), 6'd0, 8'(8'h10 + k))));
        end
        drive(6, mk(1'b0, 6'd6, 6'd1, 8'h66));
        drive(0, mk(1'b0, 6'd0, 6'd1, 8'h60));
        tick();
        bus.in_vld = '0;
        chk("t2_gap_vld", 32'(bus.out_vld), 32'd0);
        tick();
        chk("t2_wrap_first", 32'(bus.out_port), 32'd0);
        tick();
        chk("t2_wrap_second", 32'(bus.out_port), 32'd6);
        tick();
        chk("t2_idle_vld", 32'(bus.out_vld), 32'd0);

        // T3: high-class stream on ch5 starves ch1 until the guard forces it
        do_reset();
        lp = mk(1'b0, 6'd1, 6'd2, 8'hA1);
        drive(1, lp);
        drive(5, mk(1'b1, 6'd5, 6'd2, 8'd0));
        tick();
        bus.in_vld[1] = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            drive(5, mk(1'b1, 6'd5, 6'd2, 8'(e)));
            tick();
            if (e <= 8) begin
                chk("t3_hi_port", 32'(bus.out_port), 32'd5);
                chk("t3_hi_pkt", 32'(bus.out_pkt), 32'(mk(1'b1, 6'd5, 6'd2, 8'(e - 1))));
                chk("t3_hi_ev", 32'(bus.starve_ev), 32'd0);
            end else begin
                chk("t3_forced_port", 32'(bus.out_port), 32'd1);
                chk("t3_forced_pkt", 32'(bus.out_pkt), 32'(lp));
                chk("t3_forced_ev", 32'(bus.starve_ev), 32'd1);
            end
        end
        bus.in_vld = '0;
        tick();
        chk("t3_resume_pkt", 32'(bus.out_pkt), 32'(mk(1'b1, 6'd5, 6'd2, 8'd8)));
        chk("t3_resume_ev", 32'(bus.starve_ev), 32'd0);
        tick();
        chk("t3_resume_pkt2", 32'(bus.out_pkt), 32'(mk(1'b1, 6'd5, 6'd2, 8'd9)));
        tick();
        chk("t3_idle_vld", 32'(bus.out_vld), 32'd0);

        // T4: backpressure fills output register plus both FIFO entries
        do_reset();
        bus.out_rdy = 1'b0;
        p0 = mk(1'b0, 6'd2, 6'd3, 8'hB0);
        p1 = mk(1'b1, 6'd2, 6'd3, 8'hB1);
        p2 = mk(1'b0, 6'd2, 6'd3, 8'hB2);
        drive(2, p0);
        tick();
        drive(2, p1);
        tick();
        chk("t4_first_pkt", 32'(bus.out_pkt), 32'(p0));
        drive(2, p2);
        tick();
        bus.in_vld = '0;
        chk("t4_full_rdy", 32'(bus.in_rdy[2]), 32'd0);
        chk("t4_stall_vld", 32'(bus.out_vld), 32'd1);
        tick();
        tick();
        chk("t4_stall_pkt", 32'(bus.out_pkt), 32'(p0));
        chk("t4_stall_port", 32'(bus.out_port), 32'd2);
        bus.out_rdy = 1'b1;
        tick();
        chk("t4_pkt1", 32'(bus.out_pkt), 32'(p1));
        chk("t4_rdy_back", 32'(bus.in_rdy[2]), 32'd1);
        tick();
        chk("t4_pkt2", 32'(bus.out_pkt), 32'(p2));
        tick();
        chk("t4_drained", 32'(bus.out_vld), 32'd0);

        // T5: asynchronous reset mid-stream discards buffered data
        do_reset();
        bus.out_rdy = 1'b0;
        drive(0, mk(1'b0, 6'd0, 6'd4, 8'hC0));
        drive(1, mk(1'b1, 6'd1, 6'd4, 8'hC1));
        tick();
        drive(0, mk(1'b0, 6'd0, 6'd4, 8'hC2));
        drive(1, mk(1'b1, 6'd1, 6'd4, 8'hC3));
        tick();
        bus.in_vld = '0;
        chk("t5_pre_vld", 32'(bus.out_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_vld", 32'(bus.out_vld), 32'd0);
        chk("t5_async_rdy", 32'(bus.in_rdy), 32'h7F);
        chk("t5_async_pkt", 32'(bus.out_pkt), 32'd0);
        #1;
        rst_n = 1'b1;
        bus.out_rdy = 1'b1;
        tick();
        chk("t5_no_stale", 32'(bus.out_vld), 32'd0);
        drive(4, mk(1'b1, 6'd4, 6'd5, 8'hD4));
        tick();
        bus.in_vld = '0;
        chk("t5_lat_e0", 32'(bus.out_vld), 32'd0);
        tick();
        chk("t5_lat_e1", 32'(bus.out_vld), 32'd1);
        chk("t5_new_pkt", 32'(bus.out_pkt), 32'(mk(1'b1, 6'd4, 6'd5, 8'hD4)));
        chk("t5_new_port", 32'(bus.out_port), 32'd4);
        tick();
        chk("t5_after_vld", 32'(bus.out_vld), 32'd0);

        // T6: random traffic against the per-channel scoreboard
        do_reset();
        sq = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                bus.in_vld[c] = ($urandom_range(0, 1) == 1);
                bus.in_pkt[c*W +: W] = mk(($urandom_range(0, 9) < 7), 6'(c), 6'(sq), 8'(sq >> 6));
            end
            bus.out_rdy = ($urandom_range(0, 3) != 0);
            consume();
            for (int c = 0; c < N; c++)
                if (bus.in_vld[c] && bus.in_rdy[c]) q[c].push_back(bus.in_pkt[c*W +: W]);
            sq++;
            tick();
        end
        bus.in_vld  = '0;
        bus.out_rdy = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            consume();
            tick();
        end
        chk("t6_final_vld", 32'(bus.out_vld), 32'd0);
        for (int c = 0; c < N; c++) chk("t6_no_loss", 32'(q[c].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
